alu_mul_seq: RTL and testbench

//  Iterative shift-add multiply sequencer for the MIPS datapath. It executes R-type mul
//  (ALU control code 4'b1010) over WIDTH cycles instead of one combinational multiply.
//  It stalls the PC/IF path while busy and presents the product on a one-cycle done

---
 rtl/alu_mul_seq.sv | 88 ++++++++
 tb/tb_alu_mul_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier for the MIPS EX stage.
// Stalls the front end while an R-type mul runs and pulses done with the 2*WIDTH-bit product.
module alu_mul_seq #(
   parameter int         WIDTH    = 32,
   parameter logic [3:0] CTRL_MUL = 4'b1010
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       alu_ctrl_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_lo_o,
   output logic [WIDTH-1:0] result_hi_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic               accept;
   logic               last_iter;

   // Flush beats a simultaneous accept so an aborted instruction never stalls the pipe.
   assign accept    = (state == IDLE) && start_i && (alu_ctrl_i == CTRL_MUL) && !flush_i;
   assign stall_o   = accept || (state == RUN);
   assign acc_next  = mplier[0] ? (acc + mcand) : acc;
   assign last_iter = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         count       <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         done_o      <= 1'b0;
         result_lo_o <= '0;
         result_hi_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= {{WIDTH{1'b0}}, src1_i};
                  mplier <= src2_i;
                  acc    <= '0;
                  count  <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (flush_i) begin
                  state <= IDLE;
               end else begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + 1'b1;
                  // The final partial sum goes straight into the result registers.
                  if (last_iter) begin
                     state       <= DONE;
                     done_o      <= 1'b1;
                     result_lo_o <= acc_next[WIDTH-1:0];
                     result_hi_o <= acc_next[2*WIDTH-1:WIDTH];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized scoreboard bench for alu_mul_seq: products come from plain 64-bit arithmetic,
// a monitor pops the expected product whenever done pulses.
module tb_alu_mul_seq;

   localparam int         WIDTH = 32;
   localparam logic [3:0] MUL   = 4'b1010;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       aluCtrl;
   logic             flush;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] resultLo;
   logic [WIDTH-1:0] resultHi;

   logic [2*WIDTH-1:0] expQ[$];
   logic [2*WIDTH-1:0] expVal;
   int checks = 0;
   int errors = 0;

   alu_mul_seq #(.WIDTH(WIDTH), .CTRL_MUL(MUL)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .alu_ctrl_i  (aluCtrl),
      .flush_i     (flush),
      .src1_i      (src1),
      .src2_i      (src2),
      .stall_o     (stall),
      .done_o      (done),
      .result_lo_o (resultLo),
      .result_hi_o (resultHi)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Full-width unsigned product; the low half is the sign-agnostic mul result.
   function automatic logic [2*WIDTH-1:0] refProduct(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (2*WIDTH)'(a) * (2*WIDTH)'(b);
   endfunction

   // Counts every comparison and prints one FAIL line per mismatch.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding product.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 64'(done), 64'd0);
         end else begin
            expVal = expQ.pop_front();
            checkOutput("resultLo", 64'(resultLo), 64'(expVal[WIDTH-1:0]));
            checkOutput("resultHi", 64'(resultHi), 64'(expVal[2*WIDTH-1:WIDTH]));
         end
      end
   end

   // Issues one instruction and checks the stall/done timeline around it.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [3:0] ctrl, input bit holdStart, input int flushAt);
      bit isMul;
      isMul = (ctrl == MUL);
      @(negedge clk);
      start   = 1'b1;
      aluCtrl = ctrl;
      src1    = a;
      src2    = b;
      flush   = 1'b0;
      #1 checkOutput("stallAccept", 64'(stall), 64'(isMul));
      if (!isMul) begin
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            checkOutput("stallNonMul", 64'(stall), 64'd0);
            checkOutput("doneNonMul", 64'(done), 64'd0);
         end
         start = 1'b0;
         return;
      end
      if (flushAt == 0) expQ.push_back(refProduct(a, b));
      for (int k = 1; k <= WIDTH + 1; k++) begin
         @(negedge clk);
         if (!holdStart) begin
            start   = 1'b0;
            aluCtrl = 4'($urandom_range(0, 15));
         end
         src1  = $urandom;
         src2  = $urandom;
         flush = (k == flushAt);
         #1;
         if (flushAt != 0 && k > flushAt) begin
            checkOutput("stallFlushed", 64'(stall), 64'd0);
            checkOutput("doneFlushed", 64'(done), 64'd0);
            if (k >= flushAt + 3) break;
         end else if (k <= WIDTH) begin
            checkOutput("stallRun", 64'(stall), 64'd1);
            checkOutput("doneRun", 64'(done), 64'd0);
         end else begin
            checkOutput("doneDone", 64'(done), 64'd1);
            checkOutput("stallDone", 64'(stall), 64'd0);
         end
      end
      @(negedge clk);
      start   = 1'b0;
      aluCtrl = 4'd0;
      flush   = 1'b0;
      #1;
      checkOutput("stallIdle", 64'(stall), 64'd0);
      checkOutput("doneIdle", 64'(done), 64'd0);
   endtask

   // Starts a multiply, then pulses reset ten cycles in and checks the async clear.
   task automatic resetMidRun(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge clk);
      start   = 1'b1;
      aluCtrl = MUL;
      src1    = a;
      src2    = b;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 rst = 1'b1;
      #1;
      checkOutput("rstStall", 64'(stall), 64'd0);
      checkOutput("rstDone", 64'(done), 64'd0);
      checkOutput("rstLo", 64'(resultLo), 64'd0);
      checkOutput("rstHi", 64'(resultHi), 64'd0);
      #1 rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1 checkOutput("doneAfterRst", 64'(done), 64'd0);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      rst     = 1'b1;
      start   = 1'b0;
      aluCtrl = 4'd0;
      flush   = 1'b0;
      src1    = '0;
      src2    = '0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("resetStall", 64'(stall), 64'd0);
      checkOutput("resetDone", 64'(done), 64'd0);
      checkOutput("resetLo", 64'(resultLo), 64'd0);
      checkOutput("resetHi", 64'(resultHi), 64'd0);
      rst = 1'b0;

      $display("[TB] directed products");
      applyStimulus(32'd3, 32'd5, MUL, 1'b0, 0);
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, MUL, 1'b0, 0);
      applyStimulus(32'hFFFFFFFE, 32'd7, MUL, 1'b0, 0);

      $display("[TB] non-mul code passes without stall");
      applyStimulus(32'd9, 32'd9, 4'b0010, 1'b0, 0);

      $display("[TB] reset in the middle of a multiply");
      resetMidRun(32'h12345678, 32'h9ABCDEF0);
      applyStimulus(32'd2, 32'd2, MUL, 1'b0, 0);

      $display("[TB] flush in RUN, flush in IDLE, start held through DONE");
      applyStimulus(32'd11, 32'd13, MUL, 1'b0, 5);
      @(negedge clk);
      start   = 1'b1;
      aluCtrl = MUL;
      flush   = 1'b1;
      #1 checkOutput("stallIdleFlush", 64'(stall), 64'd0);
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      checkOutput("stayIdleFlush", 64'(stall), 64'd0);
      checkOutput("doneIdleFlush", 64'(done), 64'd0);
      applyStimulus(32'd6, 32'd7, MUL, 1'b1, 0);

      $display("[TB] randomized products");
      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 3))
            0:       a = '0;
            1:       a = '1;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom);
         applyStimulus(a, b, MUL, 1'($urandom_range(0, 1)), 0);
      end

      repeat (3) @(negedge clk);
      checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
